// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory arbiter: FSM states, access-size codes and requester ids.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and load extraction/extension for a 32-bit word memory.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [3:0]  wr_mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wr_mask_o = 4'b1111;
    wdata_o   = wdata_i;
    case (funct3_i)
      F3_B: begin
        wr_mask_o = 4'b0001 << addr_lo_i;
        wdata_o   = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        wr_mask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o   = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Misaligned low bits are simply ignored: halves use addr[1] only, words use neither.
  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_o = {24'b0, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_o = {16'b0, half_sel};
      default: rdata_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_arb_ctrl.sv
// Two-requester data-memory arbiter: round-robin grant, access, response; one access per 3 cycles.
// Defining DMEM_MISALIGN_TRAP_EN adds p0_err/p1_err and suppresses misaligned accesses.
module dmem_arb_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DM_ADDRESS-1:0] p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic [2:0]            p0_funct3,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_W-1:0]     p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DM_ADDRESS-1:0] p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [2:0]            p1_funct3,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic [31:0]           mem_raddress,
  output logic [31:0]           mem_waddress,
  output logic [31:0]           mem_datain,
  output logic [3:0]            mem_wr,
  input  logic [31:0]           mem_dataout,
  output logic                  busy
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic                  p0_err,
  output logic                  p1_err
`endif
);

  state_e                state_q;
  port_id_e              last_q, port_q, win;
  logic                  grant, trap, store_en, access_en;
  logic                  we_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            f3_q;
  logic                  p0_rvalid_q, p1_rvalid_q;
  logic [DATA_W-1:0]     p0_rdata_q, p1_rdata_q, resp_data;
  logic [3:0]            lane_mask;
  logic [31:0]           lane_wdata, load_data, word_addr;

  always_comb begin
    grant = (state_q == ST_IDLE) && (p0_req || p1_req) && !reset;
    if (p0_req && p1_req) win = (last_q == PORT0) ? PORT1 : PORT0;
    else if (p1_req)      win = PORT1;
    else                  win = PORT0;
  end

  assign p0_gnt = grant && (win == PORT0);
  assign p1_gnt = grant && (win == PORT1);
  assign busy   = (state_q != ST_IDLE);

  dmem_lane_align u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .word_i    (mem_dataout),
    .wr_mask_o (lane_mask),
    .wdata_o   (lane_wdata),
    .rdata_o   (load_data)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic p0_err_q, p1_err_q;

  // HU as a store code is a full-word store, so only loads trap on it.
  always_comb begin
    trap = 1'b0;
    if ((f3_q == F3_H) || (!we_q && (f3_q == F3_HU))) trap = addr_q[0];
    else if (f3_q == F3_W)                             trap = (addr_q[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p0_err_q <= 1'b0;
      p1_err_q <= 1'b0;
    end else begin
      p0_err_q <= (state_q == ST_ACCESS) && (port_q == PORT0) && trap;
      p1_err_q <= (state_q == ST_ACCESS) && (port_q == PORT1) && trap;
    end
  end

  assign p0_err = p0_err_q;
  assign p1_err = p1_err_q;
`else
  assign trap = 1'b0;
`endif

  // Memory strobes are gated by reset directly so an aborted store never writes.
  assign word_addr    = {{(32-DM_ADDRESS){1'b0}}, addr_q[DM_ADDRESS-1:2], 2'b00};
  assign access_en    = (state_q == ST_ACCESS) && !reset;
  assign store_en     = access_en && we_q;
  assign mem_raddress = access_en ? word_addr : 32'b0;
  assign mem_waddress = access_en ? word_addr : 32'b0;
  assign mem_datain   = store_en ? lane_wdata : 32'b0;
  assign mem_wr       = (store_en && !trap) ? lane_mask : 4'b0;
  assign resp_data    = (we_q || trap) ? '0 : load_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT1;
      port_q      <= PORT0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= 3'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            port_q  <= win;
            last_q  <= win;
            we_q    <= (win == PORT1) ? p1_we     : p0_we;
            addr_q  <= (win == PORT1) ? p1_addr   : p0_addr;
            wdata_q <= (win == PORT1) ? p1_wdata  : p0_wdata;
            f3_q    <= (win == PORT1) ? p1_funct3 : p0_funct3;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (port_q == PORT0) begin
            p0_rvalid_q <= 1'b1;
            p0_rdata_q  <= resp_data;
          end else begin
            p1_rvalid_q <= 1'b1;
            p1_rdata_q  <= resp_data;
          end
          state_q <= ST_RESP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arb_ctrl.sv
// Bench for dmem_arb_ctrl: transaction-level model with byte memory, directed and random traffic.
module tb_dmem_arb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [8:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [2:0]  p0_funct3, p1_funct3;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_raddress, mem_waddress, mem_datain, mem_dataout;
  logic [3:0]  mem_wr;
  logic        busy;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        p0_err, p1_err;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_arb_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_funct3(p0_funct3), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_funct3(p1_funct3), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_raddress(mem_raddress), .mem_waddress(mem_waddress), .mem_datain(mem_datain),
    .mem_wr(mem_wr), .mem_dataout(mem_dataout), .busy(busy)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .p0_err(p0_err), .p1_err(p1_err)
`endif
  );

  // Environment memory: asynchronous read, byte-enabled synchronous write.
  logic [31:0] env_mem [0:127];
  assign mem_dataout = env_mem[mem_raddress[8:2]];
  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (mem_wr[k]) env_mem[mem_waddress[8:2]][8*k +: 8] <= mem_datain[8*k +: 8];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else passes++;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:511];

  typedef struct {
    logic        port;
    logic        we;
    logic        err;
    int          base;
    int          off;
    int          size;
    logic [31:0] wdata;
    logic [3:0]  wr;
    logic [31:0] datain;
    logic [31:0] rdata;
  } txn_t;

  function automatic int acc_size(input logic [2:0] f3, input logic we);
    if (f3 == 3'd0 || (!we && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (!we && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic txn_t build(input logic port, input logic we, input logic [8:0] a,
                                 input logic [31:0] wd, input logic [2:0] f3);
    txn_t t;
    int ai;
    logic mis;
    ai      = int'(a);
    t.port  = port;
    t.we    = we;
    t.wdata = wd;
    t.size  = acc_size(f3, we);
    t.base  = ai - (ai % 4);
    t.off   = (t.size == 1) ? (ai % 4) : (t.size == 2) ? ((ai % 4) / 2) * 2 : 0;
    mis     = (t.size == 2 && (ai % 2) == 1) || (f3 == 3'd2 && (ai % 4) != 0);
    t.err   = TRAP && mis;
    t.wr    = (we && !t.err) ? 4'(((1 << t.size) - 1) << t.off) : 4'b0;
    t.datain = 32'b0;
    if (we) for (int k = 0; k < 4; k++) t.datain[8*k +: 8] = wd[8*(k % t.size) +: 8];
    t.rdata = 32'b0;
    if (!we && !t.err) begin
      for (int i = 0; i < t.size; i++) t.rdata[8*i +: 8] = ref_mem[t.base + t.off + i];
      if ((f3 == 3'd0 || f3 == 3'd1) && t.rdata[8*t.size-1])
        t.rdata = t.rdata | (32'hFFFF_FFFF << (8 * t.size));
    end
    return t;
  endfunction

  txn_t        cur;
  int          ph = 0;
  logic        last_m = 1'b1;
  logic [31:0] exp_rd [2] = '{32'b0, 32'b0};

  always @(negedge clk) begin : compare
    logic any, w;
    if (reset) begin
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_p1_gnt", p1_gnt, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_raddr", mem_raddress, 0);
      chk("rst_waddr", mem_waddress, 0);
      chk("rst_datain", mem_datain, 0);
      ph        = 0;
      last_m    = 1'b1;
      exp_rd[0] = 32'b0;
      exp_rd[1] = 32'b0;
    end else begin
      any = (ph == 0) && (p0_req || p1_req);
      w   = (p0_req && p1_req) ? !last_m : p1_req;
      chk("p0_gnt", p0_gnt, any && !w);
      chk("p1_gnt", p1_gnt, any && w);
      chk("busy", busy, ph != 0);
      chk("mem_wr", mem_wr, (ph == 1) ? cur.wr : 4'b0);
      chk("mem_raddress", mem_raddress, (ph == 1) ? 32'(cur.base) : 32'b0);
      chk("mem_waddress", mem_waddress, (ph == 1) ? 32'(cur.base) : 32'b0);
      chk("mem_datain", mem_datain, (ph == 1) ? cur.datain : 32'b0);
      chk("p0_rvalid", p0_rvalid, ph == 2 && cur.port == 1'b0);
      chk("p1_rvalid", p1_rvalid, ph == 2 && cur.port == 1'b1);
      chk("p0_rdata", p0_rdata, exp_rd[0]);
      chk("p1_rdata", p1_rdata, exp_rd[1]);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("p0_err", p0_err, ph == 2 && cur.port == 1'b0 && cur.err);
      chk("p1_err", p1_err, ph == 2 && cur.port == 1'b1 && cur.err);
`endif
      if (ph == 0) begin
        if (any) begin
          cur = w ? build(1'b1, p1_we, p1_addr, p1_wdata, p1_funct3)
                  : build(1'b0, p0_we, p0_addr, p0_wdata, p0_funct3);
          last_m = w;
          ph     = 1;
        end
      end else if (ph == 1) begin
        if (cur.we && !cur.err)
          for (int i = 0; i < cur.size; i++) ref_mem[cur.base + cur.off + i] = cur.wdata[8*i +: 8];
        exp_rd[cur.port] = cur.rdata;
        ph = 2;
      end else begin
        ph = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input logic port, input logic req, input logic we, input logic [8:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = wd; p1_funct3 = f3;
    end else begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = wd; p0_funct3 = f3;
    end
  endtask

  task automatic do_txn(input string nm, input logic port, input logic we, input logic [8:0] a,
                        input logic [31:0] wd, input logic [2:0] f3, input logic [3:0] lit_wr,
                        input logic [31:0] lit_rd, input logic lit_err);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(port, 1'b1, we, a, wd, f3);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = port ? p1_gnt : p0_gnt;
    end
    if (!got) begin
      chk({nm, "_gnt_timeout"}, 0, 1);
      set_req(port, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
      return;
    end
    @(posedge clk); #1;
    set_req(port, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    @(negedge clk);
    chk({nm, "_wr"}, mem_wr, lit_wr);
    @(negedge clk);
    chk({nm, "_rvalid"}, port ? p1_rvalid : p0_rvalid, 1);
    chk({nm, "_rdata"}, port ? p1_rdata : p0_rdata, lit_rd);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk({nm, "_err"}, port ? p1_err : p0_err, lit_err);
`else
    if (lit_err) chk({nm, "_err_flag"}, 0, 1);
`endif
  endtask

  task automatic rnd_req(input logic port);
    logic [2:0] f3;
    f3 = 3'($urandom_range(0, 7));
    set_req(port, 1'b1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom, f3);
  endtask

  int          gport [$];
  int          gcyc  [$];
  logic [31:0] word;
  logic        g0, g1;

  initial begin
    for (int w = 0; w < 128; w++) begin
      word = $urandom;
      env_mem[w] = word;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = word[8*b +: 8];
    end
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    set_req(1'b1, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_p0_rdata", p0_rdata, 0);
    chk("reset_p1_rdata", p1_rdata, 0);
    chk("reset_mem_wr", mem_wr, 0);
    chk("reset_p0_rvalid", p0_rvalid, 0);

    do_txn("sw_010", 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 4'b1111, 32'h0, 1'b0);
    do_txn("lw_010", 1'b0, 1'b0, 9'h010, 32'h0, 3'd2, 4'b0000, 32'hDEADBEEF, 1'b0);
    do_txn("lw_011", 1'b0, 1'b0, 9'h011, 32'h0, 3'd2, 4'b0000,
           TRAP ? 32'h0 : 32'hDEADBEEF, TRAP);
    do_txn("sb_013", 1'b0, 1'b1, 9'h013, 32'h000000A5, 3'd0, 4'b1000, 32'h0, 1'b0);
    do_txn("lb_013", 1'b1, 1'b0, 9'h013, 32'h0, 3'd0, 4'b0000, 32'hFFFFFFA5, 1'b0);
    do_txn("lbu_013", 1'b0, 1'b0, 9'h013, 32'h0, 3'd4, 4'b0000, 32'h000000A5, 1'b0);
    do_txn("sh_022", 1'b1, 1'b1, 9'h022, 32'h00008001, 3'd1, 4'b1100, 32'h0, 1'b0);
    do_txn("lh_022", 1'b0, 1'b0, 9'h022, 32'h0, 3'd1, 4'b0000, 32'hFFFF8001, 1'b0);
    do_txn("lhu_022", 1'b1, 1'b0, 9'h022, 32'h0, 3'd5, 4'b0000, 32'h00008001, 1'b0);

    // Store aborted by reset while in its access cycle.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 9'h030, 32'h12345678, 3'd2);
    g0 = 1'b0;
    for (int n = 0; n < 20 && !g0; n++) begin
      @(negedge clk);
      g0 = p0_gnt;
    end
    if (!g0) chk("abort_gnt_timeout", 0, 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_wr", mem_wr, 0);
    chk("abort_rvalid_a", p0_rvalid, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rvalid_b", p0_rvalid, 0);
    chk("abort_p0_rdata", p0_rdata, 0);
    word = {ref_mem[51], ref_mem[50], ref_mem[49], ref_mem[48]};
    chk("abort_word_030", env_mem[12], word);
    chk("abort_word_not_new", 32'(env_mem[12] == 32'h12345678 && word != 32'h12345678), 0);

    // Both requesters held high: grants must alternate p0,p1,... every third cycle.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 9'($urandom_range(0, 127) * 4), 32'd0, 3'd2);
    set_req(1'b1, 1'b1, 1'b0, 9'($urandom_range(0, 127) * 4), 32'd0, 3'd2);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      g0 = p0_gnt;
      g1 = p1_gnt;
      if (g0) begin gport.push_back(0); gcyc.push_back(c); end
      if (g1) begin gport.push_back(1); gcyc.push_back(c); end
      @(posedge clk); #1;
      if (g0) set_req(1'b0, 1'b1, 1'b0, 9'($urandom_range(0, 127) * 4), 32'd0, 3'd2);
      if (g1) set_req(1'b1, 1'b1, 1'b0, 9'($urandom_range(0, 127) * 4), 32'd0, 3'd2);
    end
    set_req(1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    set_req(1'b1, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    chk("rr_grant_count", gport.size(), 5);
    for (int i = 0; i < gport.size(); i++) begin
      chk("rr_grant_port", gport[i], i % 2);
      chk("rr_grant_cycle", gcyc[i], 3 * i);
    end
    repeat (4) @(posedge clk);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = p0_gnt;
      g1 = p1_gnt;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 249) == 0);
      if (g0) p0_req = 1'b0;
      if (g1) p1_req = 1'b0;
      if (!p0_req && $urandom_range(0, 2) == 0) rnd_req(1'b0);
      if (!p1_req && $urandom_range(0, 2) == 0) rnd_req(1'b1);
    end
    reset = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    set_req(1'b1, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    repeat (6) @(posedge clk);
    #1;
    for (int w = 0; w < 128; w++) begin
      word = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
      chk("final_mem_word", env_mem[w], word);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
